// File: rtl/bcp_pkg.sv
// Shared types for the BCP clause scheduler: FSM state encoding, default widths
// and the clause record layout as fetched from clause memory.
package bcp_pkg;

   localparam int BCP_VAR_NUM = 8;
   localparam int BCP_IDX_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_EVAL,
      ST_TAIL,
      ST_EMIT,
      ST_NEXT,
      ST_FIN
   } bcp_sched_state_t;

   typedef struct packed {
      logic [BCP_VAR_NUM-1:0] cl_type;
      logic [BCP_VAR_NUM-1:0] cl_mask;
      logic [BCP_VAR_NUM-1:0] cl_size;
   } bcp_clause_t;

endpackage

// File: rtl/bcp_imp_slot.sv
// One-entry valid/ready holding register for an implication; loads in one cycle,
// holds var/clause stable while out_ready is low, frees on out_valid && out_ready.
module bcp_imp_slot #(
   parameter int IDX_W = 3,
   parameter int CL_W  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [IDX_W-1:0] load_var,
   input  logic [CL_W-1:0]  load_clause,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_var,
   output logic [CL_W-1:0]  out_clause
);

   logic             valid_q, valid_d;
   logic [IDX_W-1:0] var_q, var_d;
   logic [CL_W-1:0]  clause_q, clause_d;

   always_comb begin
      valid_d  = valid_q;
      var_d    = var_q;
      clause_d = clause_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d  = 1'b1;
         var_d    = load_var;
         clause_d = load_clause;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q  <= 1'b0;
         var_q    <= '0;
         clause_q <= '0;
      end else begin
         valid_q  <= valid_d;
         var_q    <= var_d;
         clause_q <= clause_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_var    = var_q;
   assign out_clause = clause_q;

endmodule

// File: rtl/bcp_clause_scheduler.sv
// Walks every clause through one checker: fetch, load, EVAL_LEN-cycle window, harvest.
// No-hit clause costs EVAL_LEN+4 cycles; a hit stalls in EMIT until imp_ready.
module bcp_clause_scheduler
   import bcp_pkg::*;
#(
   parameter int VAR_NUM    = BCP_VAR_NUM,
   parameter int IDX_W      = BCP_IDX_W,
   parameter int CLAUSE_NUM = 16,
   parameter int CL_W       = 4,
   parameter int EVAL_LEN   = 8,
   parameter int MAX_PASS   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               fixpoint,
   output logic               busy,
   output logic               done,
   output logic               pass_limit,
   output logic [CL_W:0]      imp_count,
   output logic               mem_rd_en,
   output logic [CL_W-1:0]    mem_rd_addr,
   input  logic [VAR_NUM-1:0] mem_type,
   input  logic [VAR_NUM-1:0] mem_mask,
   input  logic [VAR_NUM-1:0] mem_size,
   output logic               chk_initial,
   output logic               chk_en,
   output logic [VAR_NUM-1:0] chk_clause_type,
   output logic [VAR_NUM-1:0] chk_clause_mask,
   output logic [VAR_NUM-1:0] chk_clause_size,
   input  logic               chk_unit_exist,
   input  logic [IDX_W-1:0]   chk_encoded_implication,
   output logic               imp_valid,
   input  logic               imp_ready,
   output logic [IDX_W-1:0]   imp_var,
   output logic [CL_W-1:0]    imp_clause
);

   localparam logic [7:0]      ECNT_LAST = 8'(EVAL_LEN - 1);
   localparam logic [7:0]      PASS_LAST = 8'(MAX_PASS - 1);
   localparam logic [CL_W-1:0] IDX_LAST  = CL_W'(CLAUSE_NUM - 1);

   bcp_sched_state_t   state_q, state_d;
   logic [CL_W-1:0]    idx_q, idx_d;
   logic [7:0]         pass_q, pass_d;
   logic [7:0]         ecnt_q, ecnt_d;
   logic               fix_q, fix_d;
   logic [CL_W:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               plim_q, plim_d;
   logic               busy_q, busy_d;
   logic               rd_en_q, rd_en_d;
   logic               init_q, init_d;
   logic               en_q, en_d;
   logic [VAR_NUM-1:0] ctype_q, ctype_d;
   logic [VAR_NUM-1:0] cmask_q, cmask_d;
   logic [VAR_NUM-1:0] csize_q, csize_d;
   logic               slot_load;
   logic               fin_done;

   // The scan ends unless fixpoint mode saw implications and passes remain.
   assign fin_done = !fix_q || (cnt_q == '0) || (pass_q >= PASS_LAST);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pass_d    = pass_q;
      ecnt_d    = ecnt_q;
      fix_d     = fix_q;
      cnt_d     = cnt_q;
      ctype_d   = ctype_q;
      cmask_d   = cmask_q;
      csize_d   = csize_q;
      done_d    = 1'b0;
      plim_d    = 1'b0;
      slot_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               fix_d   = fixpoint;
               idx_d   = '0;
               pass_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            ctype_d = mem_type;
            cmask_d = mem_mask;
            csize_d = mem_size;
            ecnt_d  = '0;
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            ecnt_d = ecnt_q + 8'd1;
            // unit_exist in the first window cycle still reflects the previous clause
            if ((ecnt_q != '0) && chk_unit_exist) begin
               slot_load = 1'b1;
               state_d   = ST_EMIT;
            end else if (ecnt_q == ECNT_LAST) begin
               state_d = ST_TAIL;
            end
         end
         ST_TAIL: begin
            if (chk_unit_exist) begin
               slot_load = 1'b1;
               state_d   = ST_EMIT;
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_EMIT: begin
            if (imp_valid && imp_ready) begin
               cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + (CL_W+1)'(1);
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (idx_q == IDX_LAST) begin
               state_d = ST_FIN;
               done_d  = fin_done;
               plim_d  = fix_q && (cnt_q != '0) && (pass_q >= PASS_LAST);
            end else begin
               idx_d   = idx_q + CL_W'(1);
               state_d = ST_FETCH;
            end
         end
         ST_FIN: begin
            if (fin_done) begin
               state_d = ST_IDLE;
            end else begin
               pass_d  = pass_q + 8'd1;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d  = (state_d != ST_IDLE);
      rd_en_d = (state_d == ST_FETCH);
      init_d  = (state_d == ST_LOAD);
      en_d    = (state_d == ST_EVAL);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pass_q  <= '0;
         ecnt_q  <= '0;
         fix_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         plim_q  <= 1'b0;
         busy_q  <= 1'b0;
         rd_en_q <= 1'b0;
         init_q  <= 1'b0;
         en_q    <= 1'b0;
         ctype_q <= '0;
         cmask_q <= '0;
         csize_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         ecnt_q  <= ecnt_d;
         fix_q   <= fix_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         plim_q  <= plim_d;
         busy_q  <= busy_d;
         rd_en_q <= rd_en_d;
         init_q  <= init_d;
         en_q    <= en_d;
         ctype_q <= ctype_d;
         cmask_q <= cmask_d;
         csize_q <= csize_d;
      end
   end

   bcp_imp_slot #(
      .IDX_W (IDX_W),
      .CL_W  (CL_W)
   ) u_imp_slot (
      .clock       (clock),
      .reset       (reset),
      .load        (slot_load),
      .load_var    (chk_encoded_implication),
      .load_clause (idx_q),
      .out_ready   (imp_ready),
      .out_valid   (imp_valid),
      .out_var     (imp_var),
      .out_clause  (imp_clause)
   );

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass_limit      = plim_q;
   assign imp_count       = cnt_q;
   assign mem_rd_en       = rd_en_q;
   assign mem_rd_addr     = idx_q;
   assign chk_initial     = init_q;
   assign chk_en          = en_q;
   assign chk_clause_type = ctype_q;
   assign chk_clause_mask = cmask_q;
   assign chk_clause_size = csize_q;

endmodule

// File: tb/tb_bcp_clause_scheduler.sv
// Directed bench for bcp_clause_scheduler with a registered clause memory and a
// behavioural checker stand-in (unit whenever the loaded mask is nonzero).
module tb_bcp_clause_scheduler;

   localparam int VAR_NUM    = 8;
   localparam int IDX_W      = 3;
   localparam int CLAUSE_NUM = 2;
   localparam int CL_W       = 1;
   localparam int EVAL_LEN   = 8;
   localparam int MAX_PASS   = 4;

   // Edge counts measured from the edge that samples start (FETCH visible at 0).
   // Clause hit at ecnt=1: FETCH,LOAD,E0,E1,EMIT,NEXT = 6 (+ stall); clean clause = EVAL_LEN+4.
   localparam int CLEAN       = EVAL_LEN + 4;
   localparam int HIT_CLAUSE  = 6;
   localparam int DONE_HIT    = HIT_CLAUSE + CLEAN;
   localparam int DONE_NOHIT  = CLAUSE_NUM * CLEAN;
   localparam int DONE_FIXLIM = MAX_PASS * (DONE_HIT + 1) - 1;

   logic               clock = 1'b0;
   logic               reset, start, fixpoint;
   logic               busy, done, pass_limit;
   logic [CL_W:0]      imp_count;
   logic               mem_rd_en;
   logic [CL_W-1:0]    mem_rd_addr;
   logic [VAR_NUM-1:0] mem_type, mem_mask, mem_size;
   logic               chk_initial, chk_en;
   logic [VAR_NUM-1:0] chk_clause_type, chk_clause_mask, chk_clause_size;
   logic               chk_unit_exist;
   logic [IDX_W-1:0]   chk_encoded_implication;
   logic               imp_valid, imp_ready;
   logic [IDX_W-1:0]   imp_var;
   logic [CL_W-1:0]    imp_clause;

   always #5 clock = ~clock;

   bcp_clause_scheduler #(
      .VAR_NUM    (VAR_NUM),
      .IDX_W      (IDX_W),
      .CLAUSE_NUM (CLAUSE_NUM),
      .CL_W       (CL_W),
      .EVAL_LEN   (EVAL_LEN),
      .MAX_PASS   (MAX_PASS)
   ) dut (
      .clock                   (clock),
      .reset                   (reset),
      .start                   (start),
      .fixpoint                (fixpoint),
      .busy                    (busy),
      .done                    (done),
      .pass_limit              (pass_limit),
      .imp_count               (imp_count),
      .mem_rd_en               (mem_rd_en),
      .mem_rd_addr             (mem_rd_addr),
      .mem_type                (mem_type),
      .mem_mask                (mem_mask),
      .mem_size                (mem_size),
      .chk_initial             (chk_initial),
      .chk_en                  (chk_en),
      .chk_clause_type         (chk_clause_type),
      .chk_clause_mask         (chk_clause_mask),
      .chk_clause_size         (chk_clause_size),
      .chk_unit_exist          (chk_unit_exist),
      .chk_encoded_implication (chk_encoded_implication),
      .imp_valid               (imp_valid),
      .imp_ready               (imp_ready),
      .imp_var                 (imp_var),
      .imp_clause              (imp_clause)
   );

   logic [VAR_NUM-1:0] m_type [CLAUSE_NUM];
   logic [VAR_NUM-1:0] m_mask [CLAUSE_NUM];
   logic [VAR_NUM-1:0] m_size [CLAUSE_NUM];

   always @(posedge clock) begin
      if (mem_rd_en) begin
         mem_type <= m_type[mem_rd_addr];
         mem_mask <= m_mask[mem_rd_addr];
         mem_size <= m_size[mem_rd_addr];
      end
   end

   function automatic logic [IDX_W-1:0] low_bit(input logic [VAR_NUM-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = VAR_NUM - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Checker stand-in: result only refreshes on en, so it stays stale across a reload.
   always @(posedge clock) begin
      if (reset) begin
         chk_unit_exist          <= 1'b0;
         chk_encoded_implication <= '0;
      end else if (chk_en) begin
         chk_unit_exist          <= (chk_clause_mask != '0);
         chk_encoded_implication <= low_bit(chk_clause_mask);
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_masks(input logic [VAR_NUM-1:0] m0, input logic [VAR_NUM-1:0] m1);
      m_type[0] = 8'hFF; m_mask[0] = m0; m_size[0] = 8'h01;
      m_type[1] = 8'hFF; m_mask[1] = m1; m_size[1] = 8'h01;
   endtask

   int first_rd, first_addr, first_init, first_en, en_mask, en_type, overlap;
   int first_valid, v_var, v_clause, nvalid, unstable, en_in_emit, xfers;
   int done_cyc, ndone, d_plim, d_cnt, busy_after;

   // Entered at a negedge; pulses start, then watches one scan for up to 'limit' edges.
   task automatic run_scan(input logic fix, input int hold, input int limit,
                           input int s1, input int s2);
      int wait_cnt;
      first_rd = -1; first_addr = -1; first_init = -1; first_en = -1;
      en_mask = -1; en_type = -1; overlap = 0;
      first_valid = -1; v_var = -1; v_clause = -1; nvalid = 0; unstable = 0;
      en_in_emit = 0; xfers = 0; done_cyc = -1; ndone = 0; d_plim = -1; d_cnt = -1;
      busy_after = -1; wait_cnt = 0;
      fixpoint = fix;
      start    = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int cyc = 0; cyc < limit; cyc++) begin
         if (mem_rd_en && first_rd < 0) begin
            first_rd = cyc; first_addr = int'(mem_rd_addr);
         end
         if (chk_initial && first_init < 0) first_init = cyc;
         if (chk_en && first_en < 0) begin
            first_en = cyc; en_mask = int'(chk_clause_mask); en_type = int'(chk_clause_type);
         end
         if (chk_initial && chk_en) overlap++;
         if (imp_valid) begin
            nvalid++;
            if (first_valid < 0) begin
               first_valid = cyc; v_var = int'(imp_var); v_clause = int'(imp_clause);
            end else if (int'(imp_var) != v_var || int'(imp_clause) != v_clause) begin
               unstable++;
            end
            if (chk_en) en_in_emit++;
            if (wait_cnt < hold) begin
               imp_ready = 1'b0; wait_cnt++;
            end else begin
               imp_ready = 1'b1;
            end
            if (imp_ready) xfers++;
         end else begin
            wait_cnt  = 0;
            imp_ready = 1'b1;
         end
         if (done) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc = cyc; d_plim = int'(pass_limit); d_cnt = int'(imp_count);
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            busy_after = int'(busy);
            break;
         end
         start = (cyc == s1 || cyc == s2);
         @(negedge clock);
      end
      start     = 1'b0;
      imp_ready = 1'b1;
   endtask

   initial begin
      int late_done;
      reset = 1'b1; start = 1'b0; fixpoint = 1'b0; imp_ready = 1'b1;
      set_masks(8'h04, 8'h00);
      mem_type = '0; mem_mask = '0; mem_size = '0;
      @(negedge clock);
      @(negedge clock);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_valid", 32'(imp_valid), 0);
      check_eq("rst_cnt", 32'(imp_count), 0);
      check_eq("rst_ctrl", 32'({mem_rd_en, chk_initial, chk_en, pass_limit}), 0);
      check_eq("rst_mask", 32'(chk_clause_mask), 0);
      reset = 1'b0;
      @(negedge clock);

      // single hit on clause 0, consumer always ready
      run_scan(1'b0, 0, 200, -1, -1);
      check_eq("hit_rd_cyc", first_rd, 0);
      check_eq("hit_rd_addr", first_addr, 0);
      check_eq("hit_init_cyc", first_init, 1);
      check_eq("hit_en_cyc", first_en, 2);
      check_eq("hit_chk_mask", en_mask, 32'h04);
      check_eq("hit_chk_type", en_type, 32'hFF);
      check_eq("hit_valid_cyc", first_valid, 4);
      check_eq("hit_var", v_var, 2);
      check_eq("hit_clause", v_clause, 0);
      check_eq("hit_xfers", xfers, 1);
      check_eq("hit_done_cyc", done_cyc, DONE_HIT);
      check_eq("hit_cnt", d_cnt, 1);
      check_eq("hit_plim", d_plim, 0);
      check_eq("hit_busy_after", busy_after, 0);
      check_eq("hit_overlap", overlap, 0);
      check_eq("hold_cnt", 32'(imp_count), 1);

      // back-pressure: ready low for 10 cycles while valid
      run_scan(1'b0, 10, 200, -1, -1);
      check_eq("bp_nvalid", nvalid, 11);
      check_eq("bp_unstable", unstable, 0);
      check_eq("bp_en_in_emit", en_in_emit, 0);
      check_eq("bp_xfers", xfers, 1);
      check_eq("bp_done_cyc", done_cyc, DONE_HIT + 10);

      // no hit anywhere
      set_masks(8'h00, 8'h00);
      run_scan(1'b0, 0, 200, -1, -1);
      check_eq("nh_nvalid", nvalid, 0);
      check_eq("nh_done_cyc", done_cyc, DONE_NOHIT);
      check_eq("nh_cnt", d_cnt, 0);

      // fixpoint converges after one quiet pass
      run_scan(1'b1, 0, 200, -1, -1);
      check_eq("fc_done_cyc", done_cyc, DONE_NOHIT);
      check_eq("fc_plim", d_plim, 0);
      check_eq("fc_ndone", ndone, 1);

      // fixpoint with a clause that always hits runs into the pass limit
      set_masks(8'h20, 8'h00);
      run_scan(1'b1, 0, 400, -1, -1);
      check_eq("fl_xfers", xfers, MAX_PASS);
      check_eq("fl_var", v_var, 5);
      check_eq("fl_done_cyc", done_cyc, DONE_FIXLIM);
      check_eq("fl_plim", d_plim, 1);
      check_eq("fl_ndone", ndone, 1);
      check_eq("fl_cnt", d_cnt, 1);

      // reset while an implication is held in EMIT
      set_masks(8'h04, 8'h00);
      run_scan(1'b0, 1000, 5, -1, -1);
      check_eq("rm_valid_before", 32'(imp_valid), 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_eq("rm_busy", 32'(busy), 0);
      check_eq("rm_valid", 32'(imp_valid), 0);
      late_done = 0;
      for (int i = 0; i < 30; i++) begin
         if (done) late_done++;
         @(negedge clock);
      end
      check_eq("rm_no_done", late_done, 0);
      run_scan(1'b0, 0, 200, -1, -1);
      check_eq("rm_rescan_addr", first_addr, 0);
      check_eq("rm_rescan_done", done_cyc, DONE_HIT);

      // start pulses while busy (including the FIN cycle) are ignored
      run_scan(1'b0, 0, 200, 3, DONE_HIT - 1);
      check_eq("sb_done_cyc", done_cyc, DONE_HIT);
      check_eq("sb_xfers", xfers, 1);
      check_eq("sb_busy_after", busy_after, 0);
      @(negedge clock);
      check_eq("sb_idle", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bcp_clause_scheduler.md
Name: bcp_clause_scheduler

Overview:
- Sequences one bcp_checker1 instance over every clause in an external clause memory: fetch record, load checker (bcp_initial), run the evaluation window (en), harvest any unit implication.
- Implications leave through a valid/ready port toward the assignment/trail logic.
- Optional fixpoint mode rescans the clause set while the previous pass produced implications.

Parameters:
- VAR_NUM, 8, variables per clause vector (matches checker width)
- IDX_W, 3, encoded implication width (log2 VAR_NUM)
- CLAUSE_NUM, 16, clauses in memory
- CL_W, 4, clause address width (log2 CLAUSE_NUM)
- EVAL_LEN, 8, en cycles per clause window (1..255)
- MAX_PASS, 4, pass limit in fixpoint mode (>=1)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begin scan (ignored unless IDLE)
- fixpoint  in  1  sampled at start; 1 = rescan until a pass yields no implication
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on scan completion
- pass_limit  out  1  valid with done; fixpoint stopped by MAX_PASS
- imp_count  out  CL_W+1  implications emitted in current/last pass; saturates at all-ones
- mem_rd_en  out  1  clause memory read strobe
- mem_rd_addr  out  CL_W  clause index
- mem_type, mem_mask, mem_size  in  VAR_NUM each  record data, valid the cycle after mem_rd_en
- chk_initial  out  1  checker bcp_initial
- chk_en  out  1  checker en
- chk_clause_type, chk_clause_mask, chk_clause_size  out  VAR_NUM each  registered record to checker
- chk_unit_exist  in  1  checker unit_exist
- chk_encoded_implication  in  IDX_W  checker encoded_implication
- imp_valid  out  1  implication available
- imp_ready  in  1  consumer accepts
- imp_var  out  IDX_W  implied variable index
- imp_clause  out  CL_W  source clause index

Behaviour:
- Reset: all outputs 0; state IDLE; clause index 0; pass count 0; imp_count 0.
- States: IDLE, FETCH, LOAD, EVAL, TAIL, EMIT, NEXT, FIN.
- IDLE: on start go FETCH; latch fixpoint; clear clause index, pass count, imp_count.
- FETCH (1 cycle): mem_rd_en=1, mem_rd_addr=index -> LOAD.
- LOAD (1 cycle): register mem_* into chk_clause_* and assert chk_initial=1 on the same cycle -> EVAL; ecnt=0.
- EVAL:
  - chk_en=1 every cycle; ecnt increments.
  - When ecnt>=1, sample chk_unit_exist. On 1, capture chk_encoded_implication into imp_var and index into imp_clause, then go EMIT.
  - In the ecnt=0 cycle unit_exist is stale from the previous clause and is ignored.
  - When ecnt reaches EVAL_LEN-1 with no hit -> TAIL.
- TAIL (1 cycle): chk_en=0; sample once more. Hit -> capture, EMIT; else NEXT.
- EMIT:
  - imp_valid=1; imp_var/imp_clause held stable until imp_valid&&imp_ready, then -> NEXT.
  - imp_count increments on acceptance.
  - chk_en=0 throughout. At most one implication per clause per pass.
- NEXT: if index==CLAUSE_NUM-1, go FIN; else index+1 and go FETCH.
- FIN, fixpoint=0: done=1 -> IDLE.
- FIN, fixpoint=1 and imp_count!=0 and pass+1<MAX_PASS: pass+1, index=0, imp_count=0 -> FETCH. No done pulse.
- FIN, fixpoint=1 and imp_count!=0 and pass+1==MAX_PASS: done=1, pass_limit=1 -> IDLE.
- FIN, fixpoint=1 and imp_count==0: done=1, pass_limit=0 -> IDLE.
- Per-clause latency, no hit: 2+EVAL_LEN+1+1 cycles (FETCH, LOAD, EVAL, TAIL, NEXT).
- Per-clause latency, hit: EMIT stall plus the cycles spent up to the hit.
- start while busy is ignored.
- reset mid-scan aborts immediately: imp_valid drops, no done, all state cleared.
- chk_initial and chk_en are never high on the same cycle.
- imp_count holds its final value after done until the next start.

Decomposition:
- Package bcp_pkg: state enum bcp_sched_state_t; VAR_NUM/IDX_W defaults; clause record struct (type, mask, size).
- No sub-module required. The implication output register is a natural small sub-module, bcp_imp_slot (1-entry valid/ready holding register).

Test Plan:
- Single-clause hit: CLAUSE_NUM=2, clause0 type=8'hFF mask=8'h04 size=1, consumer ready -> imp_valid with imp_var=3'd2 imp_clause=0; done one cycle after clause1 NEXT; imp_count=1.
- Back-pressure: imp_ready=0 for 10 cycles on a hit -> imp_valid, imp_var, imp_clause stable all 10 cycles; chk_en=0; exactly one transfer when ready rises.
- No hit: all masks 0 -> no imp_valid; done after exactly CLAUSE_NUM*(EVAL_LEN+4) cycles from start; imp_count=0.
- Fixpoint limit: a clause that always hits, fixpoint=1, MAX_PASS=4 -> four passes, done with pass_limit=1.
- Fixpoint converge: no hits -> single pass, done, pass_limit=0.
- Reset mid-EMIT: assert reset for 1 cycle -> next cycle busy=0, imp_valid=0, done never pulses. A following start rescans from clause 0.
- start during busy is ignored: scan completes with unchanged timing.
